// File: rtl/uart_bridge_pkg.sv
// Shared constants and FSM encoding for the UART command bridge.
package uart_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_WDATA,
        ST_WMEM,
        ST_RMEM,
        ST_RSEND,
        ST_ACK,
        ST_NAK
    } state_e;

    // Replace byte lane idx of a 32-bit word; used to assemble the LSB-first address.
    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = word;
        case (idx)
            2'd0: r[7:0]   = b;
            2'd1: r[15:8]  = b;
            2'd2: r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_mem_bridge.sv
// Parses read/write packets from the UART receive FIFO, drives byte-wide
// memory accesses and returns ACK/NAK or read data through the send FIFO.
module uart_mem_bridge
    import uart_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_avail,
    output logic                  rx_pop,
    output logic [7:0]            tx_byte,
    input  logic                  tx_ready,
    output logic                  tx_push,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  err_opcode
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                  state_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [8:0]              cnt_q;
    logic [TW-1:0]           timer_q;
    logic [1:0]              idx_q;
    logic                    pop_prev_q;
    logic                    push_prev_q;
    logic [7:0]              tx_byte_q;
    logic [7:0]              wdata_q;
    logic                    err_to_q;
    logic                    err_op_q;

    logic                    timed;
    logic                    expire;
    logic                    fetch;
    logic                    push;
    logic                    accept;
    logic [31:0]             addr_ins_d;
    logic [ADDR_WIDTH-1:0]   addr_inc_d;

    always_comb begin
        timed  = (state_q == ST_ADDR) || (state_q == ST_LEN) || (state_q == ST_WDATA);
        expire = timed && (timer_q == TW'(TIMEOUT_CYCLES - 1));
        // A byte arriving in the expiry cycle is left in the FIFO for IDLE to parse.
        fetch  = !RST && rx_avail && !pop_prev_q && !expire
                 && ((state_q == ST_IDLE) || timed);
        push   = !RST && tx_ready && !push_prev_q
                 && ((state_q == ST_RSEND) || (state_q == ST_ACK) || (state_q == ST_NAK));
        accept = mem_req && mem_ready;
        addr_ins_d = put_byte(32'(addr_q), idx_q, rx_byte);
        addr_inc_d = addr_q + ADDR_WIDTH'(1);
    end

    assign rx_pop      = fetch;
    assign tx_push     = push;
    assign tx_byte     = tx_byte_q;
    assign mem_req     = (state_q == ST_WMEM) || (state_q == ST_RMEM);
    assign mem_we      = (state_q == ST_WMEM);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_to_q;
    assign err_opcode  = err_op_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            idx_q       <= '0;
            pop_prev_q  <= 1'b0;
            push_prev_q <= 1'b0;
            tx_byte_q   <= '0;
            wdata_q     <= '0;
            err_to_q    <= 1'b0;
            err_op_q    <= 1'b0;
        end else begin
            pop_prev_q  <= fetch;
            push_prev_q <= push;
            err_to_q    <= 1'b0;
            err_op_q    <= 1'b0;

            if (!timed || fetch) timer_q <= '0;
            else                 timer_q <= timer_q + TW'(1);

            case (state_q)
                ST_IDLE: if (fetch) begin
                    idx_q <= '0;
                    if (rx_byte == OP_WRITE) begin
                        we_q    <= 1'b1;
                        state_q <= ST_ADDR;
                    end else if (rx_byte == OP_READ) begin
                        we_q    <= 1'b0;
                        state_q <= ST_ADDR;
                    end else begin
                        tx_byte_q <= RSP_NAK;
                        err_op_q  <= 1'b1;
                        state_q   <= ST_NAK;
                    end
                end
                ST_ADDR: if (expire) begin
                    err_to_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end else if (fetch) begin
                    addr_q <= addr_ins_d[ADDR_WIDTH-1:0];
                    idx_q  <= idx_q + 2'd1;
                    if (idx_q == 2'd3) state_q <= ST_LEN;
                end
                ST_LEN: if (expire) begin
                    err_to_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end else if (fetch) begin
                    cnt_q   <= (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
                    state_q <= we_q ? ST_WDATA : ST_RMEM;
                end
                ST_WDATA: if (expire) begin
                    err_to_q <= 1'b1;
                    state_q  <= ST_IDLE;
                end else if (fetch) begin
                    wdata_q <= rx_byte;
                    state_q <= ST_WMEM;
                end
                ST_WMEM: if (accept) begin
                    addr_q <= addr_inc_d;
                    cnt_q  <= cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        tx_byte_q <= RSP_ACK;
                        state_q   <= ST_ACK;
                    end else begin
                        state_q <= ST_WDATA;
                    end
                end
                ST_RMEM: if (accept) begin
                    tx_byte_q <= mem_rdata;
                    state_q   <= ST_RSEND;
                end
                ST_RSEND: if (push) begin
                    addr_q  <= addr_inc_d;
                    cnt_q   <= cnt_q - 9'd1;
                    state_q <= (cnt_q == 9'd1) ? ST_IDLE : ST_RMEM;
                end
                ST_ACK, ST_NAK: if (push) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Host-side command responder for the UART transceiver's byte stream.
- Consumes received bytes from the transceiver's receive FIFO and parses read/write packets.
- Performs byte-wide memory accesses and returns ACK or read data through the transceiver's send FIFO.
- Sits between the UART transceiver and the memory bus; used for program loading and debug memory peek/poke.

Parameters:
ADDR_WIDTH, 32, memory address width; the packet always carries 4 address bytes, and bits above ADDR_WIDTH are dropped.
TIMEOUT_CYCLES, 50000, idle CLK cycles allowed between bytes inside a packet before the parser aborts.

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
rx_byte  in  8  head byte of the receive FIFO (show-ahead), valid while rx_avail=1
rx_avail  in  1  receive FIFO non-empty
rx_pop  out  1  one-cycle pop of the receive FIFO head
tx_byte  out  8  byte to enqueue in the send FIFO
tx_ready  in  1  send FIFO not full
tx_push  out  1  one-cycle enqueue strobe; tx_byte valid in the same cycle
mem_req  out  1  memory request, held until accepted
mem_we  out  1  1=write, 0=read; stable while mem_req=1
mem_addr  out  ADDR_WIDTH  byte address
mem_wdata  out  8  write data
mem_rdata  in  8  read data, valid in the accept cycle
mem_ready  in  1  accept; the transfer completes in the cycle with mem_req and mem_ready both high
busy  out  1  1 whenever the FSM is not in IDLE
err_timeout  out  1  one-cycle pulse on inter-byte timeout abort
err_opcode  out  1  one-cycle pulse on an unknown opcode

Behaviour:
- Reset values: all outputs are 0 (rx_pop, tx_push, tx_byte, mem_req, mem_we, mem_addr, mem_wdata, busy, err_*).
  - FSM goes to IDLE; the address register, count register and timer are cleared.
- Packet format (bytes):
  - Write: 0x57, A0..A3 (address, LSB first), L, then L data bytes.
  - Read: 0x52, A0..A3, L.
  - L=0 means 256 bytes.
- Byte fetch rule:
  - A byte is taken when rx_avail=1 and no pop was issued in the previous cycle.
  - The bridge samples rx_byte and asserts rx_pop for exactly one cycle.
  - This gives at most one pop every 2 cycles, which allows for the FIFO status update latency.
- Byte send rule:
  - tx_push is asserted for one cycle only when tx_ready=1 and no push was issued in the previous cycle.
  - tx_byte is held until the push occurs.
- FSM states:
  - IDLE: fetch a byte. 0x57 -> ADDR with we=1. 0x52 -> ADDR with we=0. Any other value -> NAK, and pulse err_opcode.
  - ADDR: fetch 4 bytes into addr[7:0], [15:8], [23:16], [31:24] in that order, then -> LEN.
  - LEN: cnt <= (L==0 ? 256 : L), a 9-bit counter. Then go to WDATA if we=1, otherwise RMEM.
  - WDATA: fetch a byte into mem_wdata -> WMEM.
  - WMEM: hold mem_req=1, mem_we=1. On accept: addr<=addr+1, cnt<=cnt-1; then go to ACK if cnt==1, otherwise WDATA.
  - RMEM: hold mem_req=1, mem_we=0. On accept, latch mem_rdata into tx_byte -> RSEND.
  - RSEND: push tx_byte. On push: addr+1, cnt-1; then go to IDLE if cnt==1, otherwise RMEM.
  - ACK: push 0x06 -> IDLE.
  - NAK: push 0x15 -> IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: 0xFFFFFFFF+1 = 0x00000000. mem_addr is the current addr register.
- mem_req must not drop before the accept cycle.
  - mem_addr, mem_we and mem_wdata stay stable while mem_req is held.
  - mem_req deasserts in the cycle after accept unless the next access follows directly; the next access starts no earlier than the next state.
- Timeout:
  - The timer counts cycles in ADDR, LEN and WDATA while no byte is fetched, and clears on each fetch.
  - At TIMEOUT_CYCLES: go to IDLE, pulse err_timeout, and do not send ACK.
  - Memory writes already committed stay committed.
  - The timer does not run in WMEM, RMEM, RSEND, ACK or NAK; back-pressure there is unbounded.
- Simultaneous events: a byte that arrives in the same cycle as the timeout expiry is not consumed. It stays in the FIFO and is parsed as an opcode from IDLE.
- RST mid-operation: immediate abort to reset values.
  - No partial byte is pushed.
  - An in-flight mem_req is dropped; the memory side must tolerate this.

Decomposition:
- Shared package uart_bridge_pkg holds:
  - OP_WRITE=8'h57, OP_READ=8'h52, RSP_ACK=8'h06, RSP_NAK=8'h15.
  - The FSM state encoding (IDLE, ADDR, LEN, WDATA, WMEM, RMEM, RSEND, ACK, NAK).
- No sub-module; the timer, fetch/push pacing and FSM stay in one module.

Test Plan:
- Write packet 57 00 10 00 00 03 AA BB CC -> mem writes 0x1000=AA, 0x1001=BB, 0x1002=CC in order; then exactly one tx byte 0x06; busy returns to 0.
- Read packet 52 00 10 00 00 02 with memory preloaded AA, BB and mem_ready delayed 5 cycles -> tx bytes AA, BB only, in order, with no ACK.
- Opcode 0x33 -> err_opcode pulse, tx 0x15. A following 52 00 00 00 00 01 is processed normally.
- Timeout: 57 00, then silence for TIMEOUT_CYCLES -> err_timeout pulse, no tx, and no mem_req. A next byte 0x52 is treated as an opcode.
- Read 52 FF FF FF FF 00 with tx_ready toggling every 3 cycles -> exactly 256 bytes pushed. Addresses run 0xFFFFFFFF, 0x00000000 ... 0x000000FE, with no duplicates or drops and rx_pop never on consecutive cycles.
- RST asserted during WDATA of a 4-byte write after 2 writes -> all outputs at reset values next edge, no further mem_req; a fresh packet after reset succeeds.
